// File: rtl/i2s_pkg.sv
// -----------------------------------------------------------------------------
// i2s_pkg
//
// Shared definitions for the Pmod I2S2 line-in receiver and line-out
// transmitter. The package holds the frame geometry, the stereo sample type,
// the channel encoding carried on LRCK and a helper that picks the serial bit
// for a given slot position.
//
// Frame geometry (fixed by the Pmod I2S2 codec setup):
//   SAMPLE_W       : bits per audio sample (two's complement)
//   SLOT_W         : SCLK periods per channel half-frame
//   SCLK_PER_FRAME : SCLK periods per full LRCK period
//   MCLK_PER_SCLK  : MCLK periods per SCLK period
// -----------------------------------------------------------------------------
package i2s_pkg;

  localparam int unsigned SAMPLE_W       = 24;
  localparam int unsigned SLOT_W         = 32;
  localparam int unsigned SCLK_PER_FRAME = 64;
  localparam int unsigned MCLK_PER_SCLK  = 4;

  // Width of the slot bit index k (0..SLOT_W-1).
  localparam int unsigned SLOT_IDX_W = $clog2(SLOT_W);

  // Counter bits above the MCLK divider: SCLK divider plus the frame position.
  localparam int unsigned FRAME_MCLK_LOG2 = $clog2(MCLK_PER_SCLK * SCLK_PER_FRAME);

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    sample_t l;
    sample_t r;
  } stereo_sample_t;

  // LRCK level: left channel while low, right channel while high.
  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } i2s_chan_e;

  // Standard I2S slot layout: slot 0 is the one-bit delay, slots 1..SAMPLE_W
  // carry the word MSB first, the remaining slots are padding zeros.
  function automatic logic slot_bit(input sample_t                word,
                                    input logic [SLOT_IDX_W-1:0] k);
    logic [SLOT_IDX_W-1:0] idx;
    logic                  b;
    b   = 1'b0;
    idx = '0;
    if ((k >= SLOT_IDX_W'(1)) && (k <= SLOT_IDX_W'(SAMPLE_W))) begin
      idx = SLOT_IDX_W'(SAMPLE_W) - k;
      b   = word[idx];
    end
    return b;
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// -----------------------------------------------------------------------------
// i2s_clkgen
//
// I2S clock generator built from one free-running counter. Every clock output
// is a plain counter register bit, so MCLK, SCLK and LRCK are glitch-free and
// phase-locked to each other. Usable by both the transmitter and the receiver.
//
// Counter layout, p = log2(CLK_PER_MCLK):
//   cnt[p-1]       MCLK
//   cnt[p+1]       SCLK (4 MCLK per SCLK)
//   cnt[p+6:p+2]   slot bit index k within the half-frame
//   cnt[p+7]       LRCK (0 = left, 1 = right)
//
// Parameters:
//   CLK_PER_MCLK : MCLK period in clk cycles, power of two, >= 2
//
// Ports:
//   clk        in  : system clock
//   rst_n      in  : asynchronous active-low reset
//   mclk       out : master clock
//   sclk       out : serial bit clock
//   lrck       out : word select
//   next_slot  out : slot index that becomes current after the next edge
//   next_chan  out : channel that becomes current after the next edge
//   sclk_fall  out : strobe, the next edge is an SCLK falling edge
//   frame_end  out : strobe, the next edge wraps the counter to 0
// -----------------------------------------------------------------------------
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int unsigned CLK_PER_MCLK = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  mclk,
  output logic                  sclk,
  output logic                  lrck,
  output logic [SLOT_IDX_W-1:0] next_slot,
  output i2s_chan_e             next_chan,
  output logic                  sclk_fall,
  output logic                  frame_end
);

  localparam int unsigned P_LOG2  = $clog2(CLK_PER_MCLK);
  localparam int unsigned BIT_LSB = P_LOG2 + $clog2(MCLK_PER_SCLK);
  localparam int unsigned CNT_W   = P_LOG2 + FRAME_MCLK_LOG2;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // The frame length is a power of two, so natural overflow is the F-1 -> 0 wrap.
  assign cnt_nxt = cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  assign mclk = cnt[P_LOG2-1];
  assign sclk = cnt[BIT_LSB-1];
  assign lrck = cnt[CNT_W-1];

  // Strobes announce the edge about to happen so that consumers can register
  // data on exactly that edge.
  assign sclk_fall = &cnt[BIT_LSB-1:0];
  assign frame_end = &cnt;

  assign next_slot = cnt_nxt[CNT_W-2:BIT_LSB];
  assign next_chan = i2s_chan_e'(cnt_nxt[CNT_W-1]);

endmodule

// File: rtl/i2s_dac_tx.sv
// -----------------------------------------------------------------------------
// i2s_dac_tx
//
// I2S transmitter for the Pmod I2S2 line-out (DAC) path. Stereo 24-bit sample
// pairs arrive over a valid/ready handshake into a single-entry holding buffer.
// At each frame boundary the buffered pair moves into the transmit registers
// (or zeros are loaded and an underflow pulse is raised when the buffer is
// empty). SDIN is serialised in standard I2S format: one-bit delay, MSB first,
// left channel while LRCK is low.
//
// Parameters:
//   CLK_PER_MCLK : MCLK period in clk_in cycles, power of two, >= 2
//
// Ports:
//   clk_in           in      : system clock
//   rst_n_in         in      : asynchronous active-low reset
//   sample_l_in      in [24] : left sample, two's complement
//   sample_r_in      in [24] : right sample, two's complement
//   sample_valid_in  in      : sample pair valid
//   sample_ready_out out     : holding buffer empty (transfer on valid&&ready)
//   underflow_out    out     : one-cycle pulse, frame started with no sample
//   lout_mclk_out    out     : master clock
//   lout_lrck_out    out     : word select, 0 = left, 1 = right
//   lout_sclk_out    out     : serial bit clock
//   lout_sdin_out    out     : serial data to the DAC
// -----------------------------------------------------------------------------
module i2s_dac_tx
  import i2s_pkg::*;
#(
  parameter int unsigned CLK_PER_MCLK = 4
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [SAMPLE_W-1:0] sample_l_in,
  input  logic [SAMPLE_W-1:0] sample_r_in,
  input  logic                sample_valid_in,
  output logic                sample_ready_out,
  output logic                underflow_out,
  output logic                lout_mclk_out,
  output logic                lout_lrck_out,
  output logic                lout_sclk_out,
  output logic                lout_sdin_out
);

  logic                  mclk;
  logic                  sclk;
  logic                  lrck;
  logic [SLOT_IDX_W-1:0] next_slot;
  i2s_chan_e             next_chan;
  logic                  sclk_fall;
  logic                  frame_end;

  i2s_clkgen #(
    .CLK_PER_MCLK (CLK_PER_MCLK)
  ) u_clkgen (
    .clk       (clk_in),
    .rst_n     (rst_n_in),
    .mclk      (mclk),
    .sclk      (sclk),
    .lrck      (lrck),
    .next_slot (next_slot),
    .next_chan (next_chan),
    .sclk_fall (sclk_fall),
    .frame_end (frame_end)
  );

  // ---------------------------------------------------------------------------
  // Holding buffer
  // ---------------------------------------------------------------------------
  stereo_sample_t hold_q;
  logic           full_q;
  logic           accept;

  assign sample_ready_out = !full_q;
  assign accept           = sample_valid_in && !full_q;

  // A pair accepted on the boundary cycle lands in the buffer only; the
  // transmit registers see the pre-edge (empty) state, so that frame
  // underflows and the pair plays one frame later.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      full_q <= 1'b0;
      hold_q <= '0;
    end else if (frame_end && full_q) begin
      full_q <= 1'b0;
    end else if (accept) begin
      full_q   <= 1'b1;
      hold_q.l <= sample_l_in;
      hold_q.r <= sample_r_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit registers and underflow flag, touched only at frame boundaries
  // ---------------------------------------------------------------------------
  stereo_sample_t tx_q;
  logic           underflow_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tx_q        <= '0;
      underflow_q <= 1'b0;
    end else begin
      underflow_q <= frame_end && !full_q;
      if (frame_end) begin
        tx_q <= full_q ? hold_q : '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // SDIN serialiser
  // ---------------------------------------------------------------------------
  // Updated together with each SCLK falling edge using the slot that starts on
  // that edge. At the boundary the slot is 0 (always zero), so loading tx_q on
  // the same edge never exposes a half-updated word.
  logic    sdin_q;
  sample_t cur_word;

  assign cur_word = (next_chan == CH_RIGHT) ? tx_q.r : tx_q.l;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sdin_q <= 1'b0;
    end else if (sclk_fall) begin
      sdin_q <= slot_bit(cur_word, next_slot);
    end
  end

  assign underflow_out = underflow_q;
  assign lout_mclk_out = mclk;
  assign lout_lrck_out = lrck;
  assign lout_sclk_out = sclk;
  assign lout_sdin_out = sdin_q;

endmodule
